residual_coeff_writer: RTL and testbench

Collects the run/level stream produced by the CAVLC residual decoder and writes it into a 16-entry coefficient register file indexed by zigzag scan position. It sits between the CAVLC level/run decoder and the inverse zigzag / inverse transform stage, and presents `coeff_0`..`coeff_15` as a stable held block with a valid/ack handshake. Indexing is in coefficient-array space: for AC block types (2, 6), index k is scan position k+1; DC is supplied separately downstream.

---
 rtl/residual_coeff_writer.sv | 115 +++++++++++
 tb/tb_residual_coeff_writer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/residual_coeff_writer.sv
// residual_coeff_writer: places CAVLC run/level beats into a 16-entry zigzag-indexed coefficient block.
// Optional position checking is enabled by defining RESIDUAL_COEFF_WRITER_CHECK_EN.
module residual_coeff_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  block_type,
  input  logic [4:0]  total_coeff,
  input  logic [3:0]  total_zeros,
  input  logic [4:0]  max_coeff,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] level,
  input  logic [3:0]  run_before,
  output logic        out_valid,
  input  logic        out_ack,
  output logic [2:0]  block_type_out,
  output logic        err,
  output logic [15:0] coeff_0,
  output logic [15:0] coeff_1,
  output logic [15:0] coeff_2,
  output logic [15:0] coeff_3,
  output logic [15:0] coeff_4,
  output logic [15:0] coeff_5,
  output logic [15:0] coeff_6,
  output logic [15:0] coeff_7,
  output logic [15:0] coeff_8,
  output logic [15:0] coeff_9,
  output logic [15:0] coeff_10,
  output logic [15:0] coeff_11,
  output logic [15:0] coeff_12,
  output logic [15:0] coeff_13,
  output logic [15:0] coeff_14,
  output logic [15:0] coeff_15
);
  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;
  state_t state, state_nx;
  logic [15:0] coeff [16];
  logic [4:0] pos, remain, pos_nx;
  logic accept, beat, last, wr_en;
  assign accept = start && (state == IDLE || (state == HOLD && out_ack));
  assign beat   = in_valid && state == FILL;
  assign last   = remain == 5'd1;
  assign pos_nx = pos - 5'd1 - {1'b0, run_before};
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: a new block can preempt the HOLD->IDLE step when acked and started together
  always_comb begin
    state_nx = accept ? (total_coeff == 5'd0 ? HOLD : FILL) :
               (beat && last) ? HOLD :
               (state == HOLD && out_ack) ? IDLE : state;
  end
  // handshake outputs decoded from state
  always_comb begin
    in_ready  = state == FILL;
    out_valid = state == HOLD;
  end
  // coefficient file, scan position and beat counter
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) coeff[i] <= '0;
      pos <= '0;
      remain <= '0;
      block_type_out <= '0;
    end else if (accept) begin
      for (int i = 0; i < 16; i++) coeff[i] <= '0;
      pos <= total_coeff + {1'b0, total_zeros} - 5'd1;
      remain <= total_coeff;
      block_type_out <= block_type;
    end else if (beat) begin
      if (wr_en) coeff[pos[3:0]] <= level;
      remain <= remain - 5'd1;
      pos <= pos_nx;
    end
`ifdef RESIDUAL_COEFF_WRITER_CHECK_EN
  logic [4:0] max_q;
  logic err_q, bad_pos, bad_run;
  assign bad_pos = pos >= max_q;
  assign bad_run = !last && ({1'b0, pos} < 6'd1 + {2'b0, run_before});
  assign wr_en   = !err_q && !bad_pos;
  assign err     = err_q;
  // sticky error: oversized block on start, or out-of-range/underflowing position on a beat
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      err_q <= 1'b0;
      max_q <= '0;
    end else if (accept) begin
      max_q <= max_coeff;
      err_q <= ({1'b0, total_coeff} + {2'b0, total_zeros}) > {1'b0, max_coeff};
    end else if (beat && (bad_pos || bad_run)) err_q <= 1'b1;
`else
  logic unused_max;
  assign unused_max = ^max_coeff;
  assign wr_en = 1'b1;
  assign err   = 1'b0;
`endif
  assign coeff_0  = coeff[0];
  assign coeff_1  = coeff[1];
  assign coeff_2  = coeff[2];
  assign coeff_3  = coeff[3];
  assign coeff_4  = coeff[4];
  assign coeff_5  = coeff[5];
  assign coeff_6  = coeff[6];
  assign coeff_7  = coeff[7];
  assign coeff_8  = coeff[8];
  assign coeff_9  = coeff[9];
  assign coeff_10 = coeff[10];
  assign coeff_11 = coeff[11];
  assign coeff_12 = coeff[12];
  assign coeff_13 = coeff[13];
  assign coeff_14 = coeff[14];
  assign coeff_15 = coeff[15];
endmodule

// File: tb/tb_residual_coeff_writer.sv
// tb_residual_coeff_writer: directed blocks with a queue of expected coefficient blocks checked on out_valid.
module tb_residual_coeff_writer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic start = 1'b0, in_valid = 1'b0, out_ack = 1'b0;
  logic [2:0] block_type = '0;
  logic [4:0] total_coeff = '0, max_coeff = 5'd16;
  logic [3:0] total_zeros = '0, run_before = '0;
  logic [15:0] level = '0;
  logic in_ready, out_valid, err;
  logic [2:0] block_type_out;
  logic [15:0][15:0] cf;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [15:0][15:0] c;
    logic e;
    logic [2:0] bt;
  } exp_t;
  exp_t q[$];
  exp_t x;
  logic prev_ov = 1'b0;

  residual_coeff_writer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_type(block_type),
    .total_coeff(total_coeff), .total_zeros(total_zeros), .max_coeff(max_coeff),
    .in_valid(in_valid), .in_ready(in_ready), .level(level), .run_before(run_before),
    .out_valid(out_valid), .out_ack(out_ack), .block_type_out(block_type_out), .err(err),
    .coeff_0(cf[0]), .coeff_1(cf[1]), .coeff_2(cf[2]), .coeff_3(cf[3]),
    .coeff_4(cf[4]), .coeff_5(cf[5]), .coeff_6(cf[6]), .coeff_7(cf[7]),
    .coeff_8(cf[8]), .coeff_9(cf[9]), .coeff_10(cf[10]), .coeff_11(cf[11]),
    .coeff_12(cf[12]), .coeff_13(cf[13]), .coeff_14(cf[14]), .coeff_15(cf[15])
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_block(input logic [4:0] tc, input logic [3:0] tz, input logic [4:0] mc, input logic [2:0] bt);
    start = 1'b1;
    total_coeff = tc;
    total_zeros = tz;
    max_coeff = mc;
    block_type = bt;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [15:0] lv, input logic [3:0] rb);
    chk("in_ready_before_beat", {255'b0, in_ready}, 256'd1);
    in_valid = 1'b1;
    level = lv;
    run_before = rb;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  // scoreboard monitor: compare the oldest expected block on each new out_valid
  always @(negedge clk) begin
    if (rst_n && out_valid && !prev_ov) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_block got=out_valid want=no_block");
      end else begin
        x = q.pop_front();
        chk("block_coeffs", {1'b0, cf}, {1'b0, x.c});
        chk("block_err", {255'b0, err}, {255'b0, x.e});
        chk("block_type_out", {253'b0, block_type_out}, {253'b0, x.bt});
      end
    end
    prev_ov = rst_n && out_valid;
  end

  initial begin
    exp_t e;
    int n;
    // reset values
    #2;
    chk("rst_in_ready", {255'b0, in_ready}, 256'd0);
    chk("rst_out_valid", {255'b0, out_valid}, 256'd0);
    chk("rst_err", {255'b0, err}, 256'd0);
    chk("rst_bt", {253'b0, block_type_out}, 256'd0);
    chk("rst_coeffs", {1'b0, cf}, 256'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // abandoned block: reset after one of three beats
    begin_block(5'd3, 4'd2, 5'd16, 3'd1);
    beat(16'd5, 4'd1);
    chk("partial_coeff4", {240'b0, cf[4]}, 256'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_coeffs", {1'b0, cf}, 256'd0);
    chk("midrst_in_ready", {255'b0, in_ready}, 256'd0);
    chk("midrst_out_valid", {255'b0, out_valid}, 256'd0);
    chk("midrst_bt", {253'b0, block_type_out}, 256'd0);
    tick();
    rst_n = 1'b1;
    // basic block: tc=3 tz=2
    e = '0;
    e.c[4] = 16'd5;
    e.c[2] = 16'hFFFE;
    e.c[1] = 16'd1;
    e.bt = 3'd2;
    q.push_back(e);
    begin_block(5'd3, 4'd2, 5'd16, 3'd2);
    chk("start_clears", {1'b0, cf}, 256'd0);
    beat(16'd5, 4'd1);
    beat(16'hFFFE, 4'd0);
    beat(16'd1, 4'd7);
    chk("ov_4_cycles", {255'b0, out_valid}, 256'd1);
    chk("in_ready_hold", {255'b0, in_ready}, 256'd0);
    tick();
    chk("hold_stable", {255'b0, out_valid}, 256'd1);
    ack();
    chk("ack_to_idle", {255'b0, out_valid}, 256'd0);
    chk("idle_retains", {240'b0, cf[4]}, 256'd5);
    // empty block
    e = '0;
    e.bt = 3'd6;
    q.push_back(e);
    begin_block(5'd0, 4'd0, 5'd15, 3'd6);
    chk("empty_ov", {255'b0, out_valid}, 256'd1);
    chk("empty_in_ready", {255'b0, in_ready}, 256'd0);
    ack();
    // full block with in_valid toggling
    e = '0;
    for (int k = 0; k < 16; k++) e.c[k] = 16'(k + 1);
    e.bt = 3'd0;
    q.push_back(e);
    begin_block(5'd16, 4'd0, 5'd16, 3'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("gap_in_ready", {255'b0, in_ready}, 256'd1);
      beat(16'(16 - i), 4'd0);
    end
    chk("full_ov", {255'b0, out_valid}, 256'd1);
    // ack and start in the same cycle
    e = '0;
    e.c[0] = 16'd7;
    e.bt = 3'd3;
    q.push_back(e);
    out_ack = 1'b1;
    begin_block(5'd1, 4'd0, 5'd16, 3'd3);
    out_ack = 1'b0;
    chk("b2b_no_idle", {255'b0, in_ready}, 256'd1);
    chk("b2b_cleared", {1'b0, cf}, 256'd0);
    beat(16'd7, 4'd3);
    chk("b2b_ov", {255'b0, out_valid}, 256'd1);
    ack();
    // oversized block
    e = '0;
    e.bt = 3'd5;
`ifdef RESIDUAL_COEFF_WRITER_CHECK_EN
    e.e = 1'b1;
`else
    e.c[15] = 16'd3;
    e.c[14] = 16'd4;
`endif
    q.push_back(e);
    begin_block(5'd2, 4'd14, 5'd15, 3'd5);
    beat(16'd3, 4'd0);
    beat(16'd4, 4'd5);
    chk("oversize_ov", {255'b0, out_valid}, 256'd1);
    ack();
    // run overshoots position zero before the last beat
    e = '0;
    e.bt = 3'd4;
    e.c[1] = 16'd9;
`ifdef RESIDUAL_COEFF_WRITER_CHECK_EN
    e.e = 1'b1;
`else
    e.c[13] = 16'd8;
`endif
    q.push_back(e);
    begin_block(5'd2, 4'd0, 5'd16, 3'd4);
    beat(16'd9, 4'd3);
    beat(16'd8, 4'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("underflow_ov", {255'b0, out_valid}, 256'd1);
    ack();
    n = 0;
    while (q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("queue_drained", 256'(q.size()), 256'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
